prbs10_checker: RTL and testbench

Serial receive-side checker for the 10-bit PRBS stream produced by the team's LFSR pattern generator. Taps are x1, x2, x3, x7, x9, the stream is taken from the MSB, and the generator seeds to 10'b0000000001. The block self-synchronises to the incoming bit stream, then free-runs a local copy of the sequence to detect and count bit errors. It sits at the far end of a serial link under test, or on a loopback path, and reports lock status and error statistics to the test controller.

---
 rtl/prbs10_checker.sv | 131 +++++++++++++
 tb/tb_prbs10_checker.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prbs10_checker.sv
// prbs10_checker: self-synchronising bit-error checker for the 10-bit PRBS
// stream (s(t) = s(t-2)^s(t-3)^s(t-4)^s(t-8)^s(t-10)).
// HUNT loads the history from the line until LOCK_CNT consecutive
// predictions match. LOCKED free-runs the local sequence and counts
// mismatches as bit errors. LOSS_CNT consecutive misses drop back to HUNT.
// Optional feature macro: PRBS10_CHK_BITCNT_EN adds a 32-bit count of the
// valid bits sampled while locked (output bit_count).
module prbs10_checker #(
  parameter int LOCK_CNT = 16,
  parameter int LOSS_CNT = 4,
  parameter int CNT_W    = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             data_in,
  input  logic             data_valid,
  input  logic             clear_cnt,
  output logic             locked,
  output logic             bit_err,
  output logic [CNT_W-1:0] err_count
`ifdef PRBS10_CHK_BITCNT_EN
  ,
  output logic [31:0]      bit_count
`endif
);

  localparam int MATCH_W = $clog2(LOCK_CNT + 1);
  localparam int MISS_W  = $clog2(LOSS_CNT + 1);
  localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(LOCK_CNT - 1);
  localparam logic [MISS_W-1:0]  MISS_LAST  = MISS_W'(LOSS_CNT - 1);
  localparam logic [3:0]         FILL_LEN   = 4'd10;

  typedef enum logic {
    HUNT,
    LOCKED
  } state_t;

  state_t             state;
  logic [9:0]         h;
  logic [3:0]         fill_cnt;
  logic [MATCH_W-1:0] match_cnt;
  logic [MISS_W-1:0]  miss_cnt;
  logic               pred;
  logic               mismatch;
  logic               err_hit;

  assign pred     = h[1] ^ h[2] ^ h[3] ^ h[7] ^ h[9];
  assign mismatch = data_in ^ pred;
  assign err_hit  = data_valid && (state == LOCKED) && mismatch;

  // Lock FSM: history shifting, fill/match/miss counting and the lock flag.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= HUNT;
      locked    <= 1'b0;
      bit_err   <= 1'b0;
      h         <= '0;
      fill_cnt  <= '0;
      match_cnt <= '0;
      miss_cnt  <= '0;
    end else begin
      bit_err <= 1'b0;
      if (data_valid) begin
        case (state)
          HUNT: begin
            h <= {h[8:0], data_in};
            if (fill_cnt != FILL_LEN) begin
              fill_cnt <= fill_cnt + 4'd1;
            end else if ((h != '0) && !mismatch) begin
              if (match_cnt == MATCH_LAST) begin
                state     <= LOCKED;
                locked    <= 1'b1;
                match_cnt <= '0;
              end else begin
                match_cnt <= match_cnt + 1'b1;
              end
            end else begin
              match_cnt <= '0;
            end
          end
          LOCKED: begin
            h <= {h[8:0], pred};
            if (mismatch) begin
              bit_err <= 1'b1;
              if (miss_cnt == MISS_LAST) begin
                state     <= HUNT;
                locked    <= 1'b0;
                fill_cnt  <= '0;
                match_cnt <= '0;
                miss_cnt  <= '0;
              end else begin
                miss_cnt <= miss_cnt + 1'b1;
              end
            end else begin
              miss_cnt <= '0;
            end
          end
          default: begin
            state  <= HUNT;
            locked <= 1'b0;
          end
        endcase
      end
    end
  end

  // Saturating error counter; a clear overrides a same-cycle increment.
  always_ff @(posedge clock) begin
    if (!reset) begin
      err_count <= '0;
    end else if (clear_cnt) begin
      err_count <= '0;
    end else if (err_hit && (err_count != '1)) begin
      err_count <= err_count + 1'b1;
    end
  end

`ifdef PRBS10_CHK_BITCNT_EN
  // Saturating count of valid bits sampled while locked.
  always_ff @(posedge clock) begin
    if (!reset) begin
      bit_count <= '0;
    end else if (clear_cnt) begin
      bit_count <= '0;
    end else if (data_valid && (state == LOCKED) && (bit_count != '1)) begin
      bit_count <= bit_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_prbs10_checker.sv
// tb_prbs10_checker: table-driven scenarios, hand-written loss/clear/reset
// sequences and a randomized run, all compared cycle by cycle against a
// queue-based reference model of the checker's behaviour.
module tb_prbs10_checker;

  localparam int LOCK_CNT   = 16;
  localparam int LOSS_CNT   = 4;
  localparam int CNT_W      = 4;
  localparam int ERR_MAX    = (1 << CNT_W) - 1;
  localparam int STREAM_LEN = 2048;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             data_in = 1'b0;
  logic             data_valid = 1'b0;
  logic             clear_cnt = 1'b0;
  logic             locked;
  logic             bit_err;
  logic [CNT_W-1:0] err_count;
`ifdef PRBS10_CHK_BITCNT_EN
  logic [31:0]      bit_count;
`endif

  int errors = 0;
  int checks = 0;

  bit prbs [STREAM_LEN];

  // Reference model state: the sequence history as a plain bit queue.
  bit m_hist [$];
  bit m_locked;
  bit m_bit_err;
  int m_fill;
  int m_match;
  int m_miss;
  int m_err;
  longint m_bits;

  typedef struct {
    string name;
    int    nbits;
    bit    zeros;
    bit    toggle;
    int    flip_start;
    int    flip_len;
    int    flip_step;
    int    exp_locked;
    int    exp_err;
    int    exp_pulses;
    int    exp_lock_bit;
  } scen_t;

  always #5 clock = ~clock;

  prbs10_checker #(
    .LOCK_CNT (LOCK_CNT),
    .LOSS_CNT (LOSS_CNT),
    .CNT_W    (CNT_W)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .data_in    (data_in),
    .data_valid (data_valid),
    .clear_cnt  (clear_cnt),
    .locked     (locked),
    .bit_err    (bit_err),
    .err_count  (err_count)
`ifdef PRBS10_CHK_BITCNT_EN
    ,
    .bit_count  (bit_count)
`endif
  );

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void build_stream();
    for (int i = 0; i < STREAM_LEN; i++) begin
      if (i < 10) prbs[i] = (i == 9);
      else prbs[i] = prbs[i-2] ^ prbs[i-3] ^ prbs[i-4] ^ prbs[i-8] ^ prbs[i-10];
    end
  endfunction

  function automatic void model_reset();
    m_hist.delete();
    for (int i = 0; i < 10; i++) m_hist.push_back(1'b0);
    m_locked  = 1'b0;
    m_bit_err = 1'b0;
    m_fill    = 0;
    m_match   = 0;
    m_miss    = 0;
    m_err     = 0;
    m_bits    = 0;
  endfunction

  function automatic void model_step(input bit valid, input bit din, input bit clr);
    int n;
    bit pred;
    bit nz;
    m_bit_err = 1'b0;
    if (valid) begin
      n    = m_hist.size();
      pred = m_hist[n-2] ^ m_hist[n-3] ^ m_hist[n-4] ^ m_hist[n-8] ^ m_hist[n-10];
      nz   = 1'b0;
      for (int k = 1; k <= 10; k++) nz |= m_hist[n-k];
      if (!m_locked) begin
        m_hist.push_back(din);
        if (m_fill < 10) m_fill++;
        else if (nz && (din == pred)) begin
          m_match++;
          if (m_match == LOCK_CNT) begin
            m_locked = 1'b1;
            m_match  = 0;
          end
        end else m_match = 0;
      end else begin
        m_hist.push_back(pred);
        if (m_bits < 64'hFFFF_FFFF) m_bits++;
        if (din != pred) begin
          m_bit_err = 1'b1;
          if (m_err < ERR_MAX) m_err++;
          m_miss++;
          if (m_miss == LOSS_CNT) begin
            m_locked = 1'b0;
            m_fill   = 0;
            m_match  = 0;
            m_miss   = 0;
          end
        end else m_miss = 0;
      end
      void'(m_hist.pop_front());
    end
    if (clr) begin
      m_err  = 0;
      m_bits = 0;
    end
  endfunction

  task automatic checkOutput();
    check("locked", locked, m_locked);
    check("bit_err", bit_err, m_bit_err);
    check("err_count", err_count, m_err);
`ifdef PRBS10_CHK_BITCNT_EN
    check("bit_count", bit_count, m_bits);
`endif
  endtask

  task automatic applyStimulus(input bit valid, input bit din, input bit clr);
    data_valid = valid;
    data_in    = din;
    clear_cnt  = clr;
    @(posedge clock);
    #1;
    model_step(valid, din, clr);
    checkOutput();
  endtask

  task automatic do_reset();
    reset      = 1'b0;
    data_valid = 1'b0;
    data_in    = 1'b0;
    clear_cnt  = 1'b0;
    @(posedge clock);
    #1;
    model_reset();
    check("reset_locked", locked, 0);
    check("reset_bit_err", bit_err, 0);
    check("reset_err_count", err_count, 0);
    reset = 1'b1;
  endtask

  task automatic feed(input int first, input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, prbs[first+i], 1'b0);
  endtask

  initial begin
    scen_t tbl [6];
    build_stream();

    tbl[0] = '{"clean",     1000, 0, 0,   0,  0, 1, 1,  0,  0, 26};
    tbl[1] = '{"single",     400, 0, 0, 200,  1, 1, 1,  1,  1, 26};
    tbl[2] = '{"burst4",     400, 0, 0, 200,  4, 1, 1,  4,  4, 26};
    tbl[3] = '{"zeros",      100, 1, 0,   0,  0, 1, 0,  0,  0,  0};
    tbl[4] = '{"toggle",      60, 0, 1,   0,  0, 1, 1,  0,  0, 26};
    tbl[5] = '{"alternate",  300, 0, 0, 100, 40, 2, 1, 15, 20, 26};

    for (int s = 0; s < 6; s++) begin
      int vcount;
      int cyc;
      int pulses;
      int first_lock;
      bit valid;
      bit b;
      $display("[TB] scenario %s", tbl[s].name);
      do_reset();
      vcount = 0; cyc = 0; pulses = 0; first_lock = 0;
      while (vcount < tbl[s].nbits) begin
        valid = tbl[s].toggle ? (cyc % 2 == 0) : 1'b1;
        if (valid) begin
          b = tbl[s].zeros ? 1'b0 : prbs[vcount];
          if (vcount >= tbl[s].flip_start && vcount < tbl[s].flip_start + tbl[s].flip_len &&
              ((vcount - tbl[s].flip_start) % tbl[s].flip_step == 0))
            b = ~b;
          vcount++;
        end else begin
          b = ~prbs[vcount];
        end
        applyStimulus(valid, b, 1'b0);
        if (bit_err) pulses++;
        if (locked && first_lock == 0) first_lock = vcount;
        cyc++;
      end
      check({tbl[s].name, "_end_locked"}, locked, tbl[s].exp_locked);
      check({tbl[s].name, "_end_err"}, err_count, tbl[s].exp_err);
      check({tbl[s].name, "_pulses"}, pulses, tbl[s].exp_pulses);
      check({tbl[s].name, "_lock_bit"}, first_lock, tbl[s].exp_lock_bit);
    end

    // Loss of lock on the 4th consecutive miss, then relock 26 clean bits later.
    $display("[TB] sequence loss/relock");
    do_reset();
    feed(0, 100);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, ~prbs[100+i], 1'b0);
      check("loss_locked", locked, (i < 3) ? 1 : 0);
      check("loss_bit_err", bit_err, 1);
    end
    feed(104, 25);
    check("relock_early", locked, 0);
    feed(129, 1);
    check("relock_locked", locked, 1);
    check("relock_err", err_count, 4);

    // Clear coinciding with an errored bit, then reset while locked.
    $display("[TB] sequence clear/reset");
    do_reset();
    feed(0, 60);
    applyStimulus(1'b1, ~prbs[60], 1'b0);
    check("pre_clear_err", err_count, 1);
    applyStimulus(1'b1, ~prbs[61], 1'b1);
    check("clear_err", err_count, 0);
    check("clear_bit_err", bit_err, 1);
    check("clear_locked", locked, 1);
    applyStimulus(1'b1, ~prbs[62], 1'b0);
    check("post_clear_err", err_count, 1);
    do_reset();
    feed(63, 25);
    check("reset_relock_early", locked, 0);
    feed(88, 1);
    check("reset_relock", locked, 1);

    // Randomized valid gaps, line errors, junk on idle cycles and clears.
    $display("[TB] sequence random");
    do_reset();
    begin
      int idx;
      bit valid;
      bit clr;
      bit b;
      idx = 0;
      for (int cyc = 0; cyc < 1200; cyc++) begin
        valid = ($urandom_range(0, 9) < 7);
        clr   = ($urandom_range(0, 99) == 0);
        if (valid) begin
          b = prbs[idx];
          if ($urandom_range(0, 31) == 0) b = ~b;
          idx++;
        end else begin
          b = 1'($urandom_range(0, 1));
        end
        applyStimulus(valid, b, clr);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
